// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, counter width and controller state encoding for the VGA raster path.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active and sync decodes.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter bit          POL    = SYNC_POL_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_active,
  output logic             sync
);

  localparam int unsigned      Total     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] Last      = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] ActEnd    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SyncStart = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SyncEnd   = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] count_d;
  logic             active_d;
  logic             sync_d;

  // Combinational so the next axis can step on the same edge this one wraps.
  assign wrap = step && (count == Last);

  always_comb begin
    count_d = count;
    if (clear || wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count + CNT_W'(1);
    end
    // Decode the value being loaded so the flags line up with the count.
    active_d = !clear && (count_d < ActEnd);
    sync_d   = (!clear && (count_d >= SyncStart) && (count_d <= SyncEnd)) ? POL : ~POL;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      in_active <= 1'b0;
      sync      <= ~POL;
    end else begin
      count     <= count_d;
      in_active <= active_d;
      sync      <= sync_d;
    end
  end

endmodule

// File: rtl/vga_raster_ctrl.sv
// VGA raster timing controller: frame sequencing, sync generation and per-line fetch requests.
module vga_raster_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_Enable,
  input  logic             i_Line_Ack,
  input  logic             i_Clear_Underrun,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_Frame_Start,
  output logic             o_Line_Req,
  output logic [CNT_W-1:0] o_Req_Row,
  output logic             o_Underrun
);

  localparam int unsigned      HTotal  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned      VTotal  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HReqCol = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VActEnd = CNT_W'(V_ACTIVE);

  if (HTotal > MAX_TOTAL || VTotal > MAX_TOTAL) begin : g_bad_total
    $error("vga_raster_ctrl: H_TOTAL and V_TOTAL must not exceed %0d", MAX_TOTAL);
  end

  state_e           state_q, state_d;
  logic             run_q, idle_d, frame_end;
  logic             h_wrap, v_wrap, h_active, v_active;
  logic [CNT_W-1:0] next_row;
  logic             req_issue, req_drop;
  logic             line_req_q, line_req_d;
  logic [CNT_W-1:0] req_row_q, req_row_d;
  logic             underrun_q, underrun_d;
  logic             frame_start_q, frame_start_d;

  assign run_q     = (state_q != StIdle);
  assign idle_d    = (state_d == StIdle);
  assign frame_end = (o_Col == HLast) && (o_Row == VLast);

  // Counters hold at zero while idle; the IDLE->RUN edge loads 0,0 without stepping.
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (SYNC_POL)
  ) u_h_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .step     (run_q),
    .clear    (idle_d),
    .count    (o_Col),
    .wrap     (h_wrap),
    .in_active(h_active),
    .sync     (o_H_Sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (SYNC_POL)
  ) u_v_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .step     (h_wrap),
    .clear    (idle_d),
    .count    (o_Row),
    .wrap     (v_wrap),
    .in_active(v_active),
    .sync     (o_V_Sync)
  );

  // Stopping is only honoured on the last pixel of a frame, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:         if (i_Enable) state_d = StRun;
      StRun, StDrain: begin
        if (i_Enable)       state_d = StRun;
        else if (frame_end) state_d = StIdle;
        else                state_d = StDrain;
      end
      default:        state_d = StIdle;
    endcase
  end

  assign next_row  = (o_Row == VLast) ? '0 : o_Row + CNT_W'(1);
  assign req_issue = run_q && (o_Col == HReqCol) && (next_row < VActEnd);
  assign req_drop  = line_req_q && !i_Line_Ack && h_wrap;

  always_comb begin
    line_req_d = line_req_q;
    req_row_d  = req_row_q;
    if ((line_req_q && i_Line_Ack) || req_drop) begin
      line_req_d = 1'b0;
    end
    if (req_issue) begin
      line_req_d = 1'b1;
      req_row_d  = next_row;
    end
    if (idle_d) begin
      line_req_d = 1'b0;
    end
    // Set has priority over a simultaneous clear.
    underrun_d    = (req_drop && !idle_d) || (underrun_q && !i_Clear_Underrun);
    frame_start_d = (state_d == StRun) && (!run_q || (h_wrap && v_wrap));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      line_req_q    <= 1'b0;
      req_row_q     <= '0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_req_q    <= line_req_d;
      req_row_q     <= req_row_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Active      = h_active && v_active;
  assign o_Frame_Start = frame_start_q;
  assign o_Line_Req    = line_req_q;
  assign o_Req_Row     = req_row_q;
  assign o_Underrun    = underrun_q;

endmodule

// File: tb/tb_vga_raster_ctrl.sv
// Scoreboard bench for vga_raster_ctrl on a reduced raster; a cycle model predicts every output.
module tb_vga_raster_ctrl;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int POL_I = 0;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       i_Enable, i_Line_Ack, i_Clear_Underrun;
  logic       o_H_Sync, o_V_Sync, o_Active, o_Frame_Start, o_Line_Req, o_Underrun;
  logic [9:0] o_Col, o_Row, o_Req_Row;

  vga_raster_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .i_Enable        (i_Enable),
    .i_Line_Ack      (i_Line_Ack),
    .i_Clear_Underrun(i_Clear_Underrun),
    .o_H_Sync        (o_H_Sync),
    .o_V_Sync        (o_V_Sync),
    .o_Active        (o_Active),
    .o_Col           (o_Col),
    .o_Row           (o_Row),
    .o_Frame_Start   (o_Frame_Start),
    .o_Line_Req      (o_Line_Req),
    .o_Req_Row       (o_Req_Row),
    .o_Underrun      (o_Underrun)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int st; int col; int row; int req; int rrow; int und;
  } mdl_t;

  typedef struct {
    int col; int row; int hs; int vs; int act; int fs; int req; int rrow; int und;
  } exp_t;

  function automatic mdl_t model_reset();
    mdl_t m;
    m.st = ST_IDLE; m.col = 0; m.row = 0; m.req = 0; m.rrow = 0; m.und = 0;
    return m;
  endfunction

  function automatic mdl_t model_step(input mdl_t m, input logic en, input logic ack,
                                      input logic clr);
    mdl_t n;
    int   drop;
    int   nr;
    bit   last;
    n    = m;
    drop = 0;
    last = (m.col == HT - 1) && (m.row == VT - 1);
    if (m.st == ST_IDLE) n.st = en ? ST_RUN : ST_IDLE;
    else                 n.st = en ? ST_RUN : (last ? ST_IDLE : ST_DRAIN);
    if (m.st == ST_IDLE || n.st == ST_IDLE) begin
      n.col = 0;
      n.row = 0;
    end else begin
      n.col = (m.col == HT - 1) ? 0 : m.col + 1;
      n.row = (m.col == HT - 1) ? ((m.row == VT - 1) ? 0 : m.row + 1) : m.row;
    end
    if (m.req != 0 && ack) begin
      n.req = 0;
    end else if (m.req != 0 && m.st != ST_IDLE && m.col == HT - 1) begin
      n.req = 0;
      drop  = 1;
    end
    nr = (m.row == VT - 1) ? 0 : m.row + 1;
    if (m.st != ST_IDLE && n.col == HA && nr < VA) begin
      n.req  = 1;
      n.rrow = nr;
    end
    if (n.st == ST_IDLE) begin
      n.req = 0;
      drop  = 0;
    end
    n.und = (drop != 0 || (m.und != 0 && !clr)) ? 1 : 0;
    return n;
  endfunction

  function automatic exp_t model_out(input mdl_t m);
    exp_t e;
    bit   run;
    run   = (m.st != ST_IDLE);
    e.col = m.col;
    e.row = m.row;
    e.hs  = (run && m.col >= HA + HFP && m.col < HA + HFP + HS) ? POL_I : 1 - POL_I;
    e.vs  = (run && m.row >= VA + VFP && m.row < VA + VFP + VS) ? POL_I : 1 - POL_I;
    e.act = (run && m.col < HA && m.row < VA) ? 1 : 0;
    e.fs  = (m.st == ST_RUN && m.col == 0 && m.row == 0) ? 1 : 0;
    e.req = m.req;
    e.rrow = m.rrow;
    e.und = m.und;
    return e;
  endfunction

  mdl_t mdl;
  exp_t exp_q[$];
  exp_t e_cur;

  // One expectation is queued per clock edge and retired on the following falling edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mdl <= model_reset();
      exp_q.delete();
      exp_q.push_back(model_out(model_reset()));
    end else begin
      mdl <= model_step(mdl, i_Enable, i_Line_Ack, i_Clear_Underrun);
      exp_q.push_back(model_out(model_step(mdl, i_Enable, i_Line_Ack, i_Clear_Underrun)));
    end
  end

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      check_val("sb_col",   32'(o_Col),         32'(e_cur.col));
      check_val("sb_row",   32'(o_Row),         32'(e_cur.row));
      check_val("sb_hsync", 32'(o_H_Sync),      32'(e_cur.hs));
      check_val("sb_vsync", 32'(o_V_Sync),      32'(e_cur.vs));
      check_val("sb_act",   32'(o_Active),      32'(e_cur.act));
      check_val("sb_fs",    32'(o_Frame_Start), 32'(e_cur.fs));
      check_val("sb_req",   32'(o_Line_Req),    32'(e_cur.req));
      check_val("sb_rrow",  32'(o_Req_Row),     32'(e_cur.rrow));
      check_val("sb_und",   32'(o_Underrun),    32'(e_cur.und));
    end
  end

  // ---------------- pixel-source ack generator ----------------
  // 0: never ack, 1: ack on the 3rd cycle of a request, 2: ack held high
  int ack_mode = 2;
  int ack_cnt  = 0;

  always @(negedge CLK) begin
    case (ack_mode)
      0: begin
        i_Line_Ack <= 1'b0;
        ack_cnt    <= 0;
      end
      1: begin
        if (o_Line_Req) begin
          ack_cnt    <= ack_cnt + 1;
          i_Line_Ack <= (ack_cnt == 2);
        end else begin
          ack_cnt    <= 0;
          i_Line_Ack <= 1'b0;
        end
      end
      default: begin
        i_Line_Ack <= 1'b1;
        ack_cnt    <= 0;
      end
    endcase
  end

  // ---------------- stimulus helpers ----------------
  int cnt_fs, cnt_hs, cnt_vs, cnt_act, cnt_req, cnt_req_cyc, cnt_und;

  task automatic run_count(input int n);
    logic prev_req;
    prev_req = o_Line_Req;
    cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_act = 0;
    cnt_req = 0; cnt_req_cyc = 0; cnt_und = 0;
    repeat (n) begin
      @(negedge CLK);
      if (o_Frame_Start) cnt_fs++;
      if (o_H_Sync == 1'b0) cnt_hs++;
      if (o_V_Sync == 1'b0) cnt_vs++;
      if (o_Active) cnt_act++;
      if (o_Line_Req && !prev_req) cnt_req++;
      if (o_Line_Req) cnt_req_cyc++;
      if (o_Underrun) cnt_und++;
      prev_req = o_Line_Req;
    end
  endtask

  task automatic wait_pos(input int r, input int c);
    int  k;
    bit  found;
    k     = 0;
    found = 1'b0;
    while (!found && k < 2 * FRAME) begin
      @(negedge CLK);
      k++;
      found = (o_Row == 10'(r)) && (o_Col == 10'(c));
    end
    if (!found) check_val("wait_pos", 32'(o_Row) * 1024 + 32'(o_Col), 32'(r * 1024 + c));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_col"},   32'(o_Col),         32'd0);
    check_val({tag, "_row"},   32'(o_Row),         32'd0);
    check_val({tag, "_hsync"}, 32'(o_H_Sync),      32'd1);
    check_val({tag, "_vsync"}, 32'(o_V_Sync),      32'd1);
    check_val({tag, "_act"},   32'(o_Active),      32'd0);
    check_val({tag, "_fs"},    32'(o_Frame_Start), 32'd0);
    check_val({tag, "_req"},   32'(o_Line_Req),    32'd0);
    check_val({tag, "_rrow"},  32'(o_Req_Row),     32'd0);
    check_val({tag, "_und"},   32'(o_Underrun),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST_N = 1'b0;
    i_Enable = 1'b0;
    i_Clear_Underrun = 1'b0;
    ack_mode = 2;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    check_reset_outputs("idle");

    // Two free-running frames with a permanently high ack.
    i_Enable = 1'b1;
    run_count(2 * FRAME);
    check_val("fs_count",   32'(cnt_fs),  32'd2);
    check_val("hsync_low",  32'(cnt_hs),  32'(2 * HS * VT));
    check_val("vsync_low",  32'(cnt_vs),  32'(2 * VS * HT));
    check_val("active_cyc", 32'(cnt_act), 32'(2 * HA * VA));
    check_val("req_free",   32'(cnt_req), 32'(2 * VA));

    // One frame with the ack arriving three cycles into each request.
    ack_mode = 1;
    run_count(FRAME);
    check_val("req_count",  32'(cnt_req),     32'(VA));
    check_val("req_cycles", 32'(cnt_req_cyc), 32'(3 * VA));
    check_val("und_none",   32'(cnt_und),     32'd0);

    // Starve one line: the request must be held then dropped with an underrun.
    wait_pos(5, 0);
    ack_mode = 0;
    wait_pos(5, HT - 1);
    check_val("req_held", 32'(o_Line_Req), 32'd1);
    check_val("req_row6", 32'(o_Req_Row),  32'd6);
    @(negedge CLK);
    check_val("req_dropped", 32'(o_Line_Req), 32'd0);
    check_val("und_set",     32'(o_Underrun), 32'd1);
    wait_pos(6, HT - 1);
    i_Clear_Underrun = 1'b1;
    @(negedge CLK);
    check_val("und_set_wins", 32'(o_Underrun), 32'd1);
    ack_mode = 1;
    @(negedge CLK);
    i_Clear_Underrun = 1'b0;
    check_val("und_cleared", 32'(o_Underrun), 32'd0);

    // Drop enable mid-frame: the frame completes, then the controller idles.
    wait_pos(3, 0);
    i_Enable = 1'b0;
    wait_pos(VT - 1, HT - 1);
    @(negedge CLK);
    check_reset_outputs("drained");
    repeat (5) @(negedge CLK);

    // Re-enable during drain: the next frame must follow with no gap.
    i_Enable = 1'b1;
    wait_pos(3, 0);
    i_Enable = 1'b0;
    wait_pos(8, 0);
    i_Enable = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!o_Frame_Start && n < 2 * FRAME);
    check_val("drain_gap", 32'(n), 32'((VT - 8) * HT));

    // Asynchronous reset in the middle of a line with a request outstanding.
    ack_mode = 0;
    wait_pos(6, 20);
    check_val("pre_rst_req",  32'(o_Line_Req), 32'd1);
    check_val("pre_rst_rrow", 32'(o_Req_Row),  32'd7);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    ack_mode = 2;
    @(negedge CLK);
    check_val("restart_col", 32'(o_Col),         32'd0);
    check_val("restart_row", 32'(o_Row),         32'd0);
    check_val("restart_fs",  32'(o_Frame_Start), 32'd1);
    repeat (60) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
